// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: buffers ALU and LSU results in
// per-source FIFOs and drives the single write port round-robin.

module regfile_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_valid_i,
    input  logic [4:0]      push_rd_i,
    input  logic [XLEN-1:0] push_data_i,
    input  logic            pop_i,
    output logic            ready_o,
    output logic            not_empty_o,
    output logic [4:0]      head_rd_o,
    output logic [XLEN-1:0] head_data_o,
    output logic [31:0]     pend_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t       mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            enq, deq;

    assign ready_o     = (count_q != CW'(DEPTH));
    assign not_empty_o = (count_q != '0);
    assign head_rd_o   = mem_q[rd_ptr_q].rd;
    assign head_data_o = mem_q[rd_ptr_q].data;

    // Writes to x0 complete the handshake but are dropped here.
    assign enq = push_valid_i && ready_o && (push_rd_i != 5'd0);
    assign deq = pop_i && not_empty_o;

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(enq) - CW'(deq);
        if (deq) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (enq) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked in vld_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= wb_entry_t'{rd: push_rd_i, data: push_data_i};
        end
    end

    always_comb begin
        pend_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend_o[mem_q[PW'(i)].rd] = 1'b1;
            end
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic [31:0]     pend_mask
);
    logic            alu_ne, lsu_ne;
    logic [4:0]      alu_head_rd, lsu_head_rd;
    logic [XLEN-1:0] alu_head_data, lsu_head_data;
    logic [31:0]     alu_pend, lsu_pend;
    logic            grant_alu, grant_lsu;

    logic            we3_q, we3_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic            last_lsu_q, last_lsu_d;

    regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_alu_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (alu_valid),
        .push_rd_i    (alu_rd),
        .push_data_i  (alu_data),
        .pop_i        (grant_alu),
        .ready_o      (alu_ready),
        .not_empty_o  (alu_ne),
        .head_rd_o    (alu_head_rd),
        .head_data_o  (alu_head_data),
        .pend_o       (alu_pend)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_lsu_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (lsu_valid),
        .push_rd_i    (lsu_rd),
        .push_data_i  (lsu_data),
        .pop_i        (grant_lsu),
        .ready_o      (lsu_ready),
        .not_empty_o  (lsu_ne),
        .head_rd_o    (lsu_head_rd),
        .head_data_o  (lsu_head_data),
        .pend_o       (lsu_pend)
    );

    // Round-robin: on a tie the source not granted last wins.
    always_comb begin
        grant_lsu  = lsu_ne && (!alu_ne || !last_lsu_q);
        grant_alu  = alu_ne && !grant_lsu;
        we3_d      = grant_alu || grant_lsu;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        last_lsu_d = last_lsu_q;
        if (grant_lsu) begin
            a3_d       = lsu_head_rd;
            wd3_d      = lsu_head_data;
            last_lsu_d = 1'b1;
        end else if (grant_alu) begin
            a3_d       = alu_head_rd;
            wd3_d      = alu_head_data;
            last_lsu_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            last_lsu_q <= 1'b0;
        end else begin
            we3_q      <= we3_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            last_lsu_q <= last_lsu_d;
        end
    end

    assign we3 = we3_q;
    assign a3  = a3_q;
    assign wd3 = wd3_q;

    always_comb begin
        pend_mask = alu_pend | lsu_pend;
        if (we3_q) begin
            pend_mask[a3_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// against a queue-based model of the write-back path.

module tb_regfile_wb_arbiter;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, lsu_valid;
    logic [4:0]      alu_rd, lsu_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            alu_ready, lsu_ready;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic [31:0]     pend_mask;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            alu_q[$];
    ent_t            lsu_q[$];
    logic            m_we3;
    logic [4:0]      m_a3;
    logic [XLEN-1:0] m_wd3;
    bit              m_last_lsu;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (alu_q[i]) m[alu_q[i].rd] = 1'b1;
        foreach (lsu_q[i]) m[lsu_q[i].rd] = 1'b1;
        if (m_we3) m[m_a3] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        bit ar, lr, ga, gl;
        @(posedge clk);
        if (rst) begin
            alu_q.delete();
            lsu_q.delete();
            m_we3 = 1'b0; m_a3 = '0; m_wd3 = '0; m_last_lsu = 1'b0;
        end else begin
            ar = (alu_q.size() != DEPTH);
            lr = (lsu_q.size() != DEPTH);
            gl = (lsu_q.size() > 0) && (alu_q.size() == 0 || !m_last_lsu);
            ga = (alu_q.size() > 0) && !gl;
            m_we3 = ga || gl;
            if (gl) begin
                m_a3 = lsu_q[0].rd; m_wd3 = lsu_q[0].data; void'(lsu_q.pop_front()); m_last_lsu = 1'b1;
            end else if (ga) begin
                m_a3 = alu_q[0].rd; m_wd3 = alu_q[0].data; void'(alu_q.pop_front()); m_last_lsu = 1'b0;
            end
            if (alu_valid && ar && alu_rd != 5'd0) alu_q.push_back('{alu_rd, alu_data});
            if (lsu_valid && lr && lsu_rd != 5'd0) lsu_q.push_back('{lsu_rd, lsu_data});
        end
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== '0 || pend_mask !== '0 || alu_ready !== 1'b1 || lsu_ready !== 1'b1)
            $display("FAIL reset_init: got we3=%b a3=%0d wd3=%h mask=%h ar=%b lr=%b expected 0/0/0/0/1/1",
                     we3, a3, wd3, pend_mask, alu_ready, lsu_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 3); alu_data = $urandom;
            lsu_valid = 1'b1; lsu_rd = 5'(i + 12); lsu_data = $urandom;
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (we3 !== 1'b0 || pend_mask !== '0 || alu_ready !== 1'b1 || lsu_ready !== 1'b1)
            $display("FAIL reset_mid: got we3=%b mask=%h ar=%b lr=%b expected we3=0 mask=0 ar=1 lr=1",
                     we3, pend_mask, alu_ready, lsu_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (we3 !== 1'b0 || pend_mask !== '0)
            $display("FAIL reset_discard: got we3=%b mask=%h expected we3=0 mask=0", we3, pend_mask);
        else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        n_checks++;
        if (we3 !== 1'b0 || pend_mask !== 32'h20)
            $display("FAIL latency_k: got we3=%b mask=%h expected we3=0 mask=00000020", we3, pend_mask);
        else n_pass++;
        tick();
        n_checks++;
        if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF || pend_mask !== 32'h20)
            $display("FAIL latency_k1: got we3=%b a3=%0d wd3=%h mask=%h expected 1/5/deadbeef/00000020",
                     we3, a3, wd3, pend_mask);
        else n_pass++;
        tick();
        n_checks++;
        if (we3 !== 1'b0 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF || pend_mask !== '0)
            $display("FAIL latency_hold: got we3=%b a3=%0d wd3=%h mask=%h expected 0/5/deadbeef/0",
                     we3, a3, wd3, pend_mask);
        else n_pass++;
    endtask

    task automatic test_tie();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (we3 !== 1'b1 || a3 !== 5'd2 || wd3 !== 32'h22)
            $display("FAIL tie_first: got we3=%b a3=%0d wd3=%h expected 1/2/00000022", we3, a3, wd3);
        else n_pass++;
        tick();
        n_checks++;
        if (we3 !== 1'b1 || a3 !== 5'd1 || wd3 !== 32'h11)
            $display("FAIL tie_second: got we3=%b a3=%0d wd3=%h expected 1/1/00000011", we3, a3, wd3);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [4:0]      a_rd [3] = '{5'd3, 5'd4, 5'd10};
        logic [4:0]      l_rd [3] = '{5'd20, 5'd21, 5'd22};
        logic [XLEN-1:0] a_dat[3];
        logic [XLEN-1:0] l_dat[3];
        logic [XLEN-1:0] got[$];
        int ai = 0, li = 0, cyc = 0;
        bit saw_full = 0, acc_a, acc_l, ready_bad = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin a_dat[i] = $urandom; l_dat[i] = $urandom; end
        while ((ai < 3 || li < 3 || alu_q.size() > 0 || lsu_q.size() > 0 || m_we3) && cyc < 30) begin
            alu_valid = (ai < 3); alu_rd = a_rd[ai % 3]; alu_data = a_dat[ai % 3];
            lsu_valid = (li < 3); lsu_rd = l_rd[li % 3]; lsu_data = l_dat[li % 3];
            if (alu_ready !== (alu_q.size() != DEPTH)) ready_bad = 1;
            if (alu_valid && !alu_ready) saw_full = 1;
            acc_a = alu_valid && alu_ready;
            acc_l = lsu_valid && lsu_ready;
            tick();
            if (acc_a) ai++;
            if (acc_l) li++;
            if (we3 === 1'b1 && (a3 == 5'd3 || a3 == 5'd4 || a3 == 5'd10)) got.push_back(wd3);
            cyc++;
        end
        idle_inputs();
        n_checks++;
        if (cyc >= 30) $display("FAIL bp_timeout: got %0d cycles expected drain before 30", cyc);
        else n_pass++;
        n_checks++;
        if (!saw_full || ready_bad)
            $display("FAIL bp_ready: got saw_full=%0d ready_bad=%0d expected saw_full=1 ready_bad=0", saw_full, ready_bad);
        else n_pass++;
        n_checks++;
        if (got.size() != 3 || got[0] !== a_dat[0] || got[1] !== a_dat[1] || got[2] !== a_dat[2])
            $display("FAIL bp_order: got %0d ALU writes expected 3 in order %h %h %h", got.size(), a_dat[0], a_dat[1], a_dat[2]);
        else n_pass++;
    endtask

    task automatic test_x0();
        do_reset();
        n_checks++;
        if (lsu_ready !== 1'b1) $display("FAIL x0_ready: got %b expected 1", lsu_ready);
        else n_pass++;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hCAFEF00D;
        tick();
        idle_inputs();
        n_checks++;
        if (pend_mask !== '0 || lsu_ready !== 1'b1)
            $display("FAIL x0_mask: got mask=%h lr=%b expected mask=0 lr=1", pend_mask, lsu_ready);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (we3 !== 1'b0) $display("FAIL x0_we3: got %b expected 0 (cycle %0d)", we3, i);
            else n_pass++;
        end
    endtask

    task automatic test_pend_mask();
        logic [31:0] exp_m[3] = '{32'h280, 32'h280, 32'h080};
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = (i < 3) ? exp_m[i] : 32'h0;
            n_checks++;
            if (pend_mask !== e) $display("FAIL pend_step%0d: got %h expected %h", i, pend_mask, e);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            lsu_valid = ($urandom_range(0, 99) < 60);
            lsu_rd    = 5'($urandom_range(0, 31));
            lsu_data  = $urandom;
            if (c == 200) rst = 1'b1;
            n_checks++;
            if (alu_ready !== (alu_q.size() != DEPTH) || lsu_ready !== (lsu_q.size() != DEPTH))
                $display("FAIL rand_ready cyc %0d: got ar=%b lr=%b expected ar=%b lr=%b",
                         c, alu_ready, lsu_ready, alu_q.size() != DEPTH, lsu_q.size() != DEPTH);
            else n_pass++;
            tick();
            rst = 1'b0;
            n_checks++;
            if (we3 !== m_we3 || a3 !== m_a3 || wd3 !== m_wd3)
                $display("FAIL rand_wport cyc %0d: got we3=%b a3=%0d wd3=%h expected we3=%b a3=%0d wd3=%h",
                         c, we3, a3, wd3, m_we3, m_a3, m_wd3);
            else n_pass++;
            n_checks++;
            if (pend_mask !== model_mask())
                $display("FAIL rand_mask cyc %0d: got %h expected %h", c, pend_mask, model_mask());
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m_we3 = 1'b0; m_a3 = '0; m_wd3 = '0; m_last_lsu = 1'b0;
        #2;
        test_reset();
        test_latency();
        test_tie();
        test_backpressure();
        test_x0();
        test_pend_mask();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
